count_sequencer: RTL
====================

Name: count_sequencer

Overview:
- Controller that sequences a WIDTH-bit counter datapath: start, pause/resume without losing the count, stop/clear, and terminal-count detection.
- Supports one-shot and auto-reload modes, counting up or down between 0 and a programmable limit.
- Sits between a control register interface and the counter; provides the run/pause semantics of a T-enable counter on a single synchronous clock.

Parameters:
- WIDTH, 4, counter and limit width in bits.
- PRESCALE, 4, clocks per count step; used only when COUNT_PRESCALE_EN is defined; must be >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a count sequence (sampled in IDLE or DONE).
- hold  in  1  level; pause counting while high.
- stop  in  1  abort and clear to IDLE.
- mode  in  1  0 = one-shot, 1 = auto-reload.
- dir  in  1  0 = up, 1 = down.
- limit  in  WIDTH  terminal value; sampled on accepted start.
- count  out  WIDTH  current count.
- tc  out  1  one-cycle terminal-count pulse, registered.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE.

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, tc=0, busy=0, done=0, internal limit_q=0.
- States: IDLE, RUN, PAUSE, DONE. Input priority each cycle: stop > hold > start.
- Definitions: start value sv = 0 (up) or limit_q (down); end value ev = limit_q (up) or 0 (down). dir and mode are sampled with limit at start and held as dir_q/mode_q.
- IDLE: count held at 0. On start: limit_q<=limit, next state RUN, count<=sv. Latency: start in cycle n gives count=sv and busy=1 in n+1; first step in n+2.
- RUN, no hold, step cycle, count!=ev: count +/-1 modulo 2^WIDTH (no wrap occurs in practice, since the sequence stays in 0..limit_q).
- RUN, step cycle, count==ev:
  - auto-reload: count<=sv, stay in RUN, tc=1 next cycle.
  - one-shot: count holds ev, go to DONE, tc=1 next cycle.
- tc is high exactly one cycle per terminal event and is never high in consecutive cycles unless limit_q=0 in auto-reload mode, where it is high every step cycle.
- hold=1 in RUN: go to PAUSE; no step in that cycle; count frozen.
- PAUSE: count frozen. hold=0: return to RUN; stepping resumes from the frozen value (no reset, no skip).
- start while in RUN or PAUSE: ignored; limit changes are ignored until the next accepted start.
- DONE: done=1, count holds ev. start: reload exactly as from IDLE. stop: go to IDLE.
- stop in RUN, PAUSE or DONE: next cycle IDLE, count=0, tc=0, done=0. stop coincident with a terminal step: stop wins, no tc.
- limit=0: sv==ev. One-shot reaches DONE after the first step cycle; auto-reload pulses tc every step cycle.
- Async reset mid-sequence: immediate return to reset values; no tc is generated.

Optional Feature:
- Macro COUNT_PRESCALE_EN.
- Defined: a step cycle occurs only when an internal prescaler (0..PRESCALE-1) wraps to 0.
  - The prescaler clears on an accepted start and on stop.
  - It freezes in PAUSE.
  - It counts only in RUN.
- Undefined: every RUN cycle is a step cycle; no prescaler logic is present.

Decomposition:
- Shared package/header count_pkg:
  - state encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE (2-bit);
  - MODE_ONESHOT/MODE_RELOAD;
  - DIR_UP/DIR_DOWN constants.
- One sub-module, count_core: WIDTH-bit synchronous counter with load, load value, enable and direction, plus an eq_end compare output.
- The FSM, the limit/mode/dir capture and tc generation stay in count_sequencer.

Test Plan:
- Up one-shot, limit=5, start pulse, macro off -> count 0,1,2,3,4,5; tc one cycle after count first shows 5; done=1, count stays 5.
- Down auto-reload, limit=3 -> count 3,2,1,0,3,2...; tc pulses in each cycle where count reloads to 3; busy stays 1.
- Up, limit=9, hold asserted at count=4 for 6 cycles -> count stays 4 and busy=1; after release count goes 5,6...; tc after 9.
- Stop at count=7 (limit=12) with start held high simultaneously -> IDLE next cycle, count=0, no tc; after stop is deasserted, start restarts from 0.
- limit=0 one-shot -> DONE two cycles after start, tc exactly once. limit=0 auto-reload -> tc every cycle while in RUN.
- COUNT_PRESCALE_EN, PRESCALE=4, up, limit=2 -> count changes every 4 clocks. Async reset asserted mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/count_pkg.sv
// Shared definitions for the count sequencer: FSM state encoding and the
// mode/direction constants used when decoding the control inputs.
package count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

endpackage

// File: rtl/count_core.sv
// WIDTH-bit up/down counter with synchronous load and enable; eq_end flags
// that the current count equals the supplied end value.
module count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] end_val,
    output logic [WIDTH-1:0] count,
    output logic             eq_end
);
    import count_pkg::*;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (dir == DIR_DOWN) count <= count - WIDTH'(1);
            else                 count <= count + WIDTH'(1);
        end
    end

    assign eq_end = (count == end_val);

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/stop sequencer for a WIDTH-bit counter with one-shot and
// auto-reload modes. Optional step prescaler enabled by COUNT_PRESCALE_EN.
module count_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    input  logic             stop,
    input  logic             mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);
    import count_pkg::*;

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("count_sequencer: PRESCALE must be >= 2");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] limit_q;
    logic             dir_q, mode_q;
    logic [WIDTH-1:0] sv, ev;
    logic             core_load, core_en, eq_end;
    logic [WIDTH-1:0] core_val;
    logic             capture, tc_nxt, step;

    assign sv = (dir_q == DIR_DOWN) ? limit_q : '0;
    assign ev = (dir_q == DIR_DOWN) ? '0 : limit_q;

`ifdef COUNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] presc;
    logic          presc_run;

    assign step      = (presc == PW'(PRESCALE - 1));
    assign presc_run = (state == ST_RUN) && !stop && !hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (stop || capture) begin
            presc <= '0;
        end else if (presc_run) begin
            presc <= step ? '0 : presc + PW'(1);
        end
    end
`else
    assign step = 1'b1;
`endif

    // Next state, counter control and terminal-count decode; priority stop > hold > start
    always_comb begin
        state_nxt = state;
        core_load = 1'b0;
        core_en   = 1'b0;
        core_val  = sv;
        capture   = 1'b0;
        tc_nxt    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    core_load = 1'b1;
                    core_val  = '0;
                    state_nxt = ST_IDLE;
                end else if (!hold && start) begin
                    capture   = 1'b1;
                    core_load = 1'b1;
                    core_val  = (dir == DIR_DOWN) ? limit : '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    core_load = 1'b1;
                    core_val  = '0;
                    state_nxt = ST_IDLE;
                end else if (hold) begin
                    state_nxt = ST_PAUSE;
                end else if (step) begin
                    if (eq_end) begin
                        tc_nxt = 1'b1;
                        if (mode_q == MODE_RELOAD) core_load = 1'b1;
                        else                       state_nxt = ST_DONE;
                    end else begin
                        core_en = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    core_load = 1'b1;
                    core_val  = '0;
                    state_nxt = ST_IDLE;
                end else if (!hold) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            tc      <= 1'b0;
            limit_q <= '0;
            dir_q   <= DIR_UP;
            mode_q  <= MODE_ONESHOT;
        end else begin
            state <= state_nxt;
            tc    <= tc_nxt;
            if (capture) begin
                limit_q <= limit;
                dir_q   <= dir;
                mode_q  <= mode;
            end
        end
    end

    count_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .load_val (core_val),
        .en       (core_en),
        .dir      (dir_q),
        .end_val  (ev),
        .count    (count),
        .eq_end   (eq_end)
    );

    assign busy = (state == ST_RUN) || (state == ST_PAUSE);
    assign done = (state == ST_DONE);

endmodule
